// File: rtl/game_pkg.sv
// Shared game-side types: frame writer state encoding.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPix,
    StSetup,
    StStrobe,
    StDone
  } FwState;

endpackage

// File: rtl/sram_pkg.sv
// SRAM geometry, default frame constants and the RGB888 -> RGB565 packer.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_COUNT = 20;
  localparam int unsigned SRAM_DATA_WIDTH = 16;
  localparam int unsigned SRAM_FRAME_W    = 640;
  localparam int unsigned SRAM_FRAME_H    = 480;
  localparam int unsigned SRAM_BASE_ADDR  = 0;

  // Keeps the top bits of each channel: {R[7:3], G[7:2], B[7:3]}.
  function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
    logic unused_low_bits;
    unused_low_bits = ^{rgb[18:16], rgb[9:8], rgb[2:0]};
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

endpackage

// File: rtl/sram_frame_writer.sv
// Streams RGB888 pixels into the SRAM frame buffer as RGB565, one timed write per pixel.
// Optional running data checksum output enabled by FRAME_WRITER_CHECKSUM_EN.
module sram_frame_writer
  import sram_pkg::*;
  import game_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = sram_pkg::SRAM_ADDR_COUNT,
  parameter int unsigned DATA_WIDTH = sram_pkg::SRAM_DATA_WIDTH,
  parameter int unsigned FRAME_W    = sram_pkg::SRAM_FRAME_W,
  parameter int unsigned FRAME_H    = sram_pkg::SRAM_FRAME_H,
  parameter int unsigned BASE_ADDR  = sram_pkg::SRAM_BASE_ADDR
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [23:0]                i_pixel,
  input  logic                       i_pixel_valid,
  output logic                       o_pixel_ready,
  output logic                       o_sram_writing,
  output logic                       o_sram_we_n,
  output logic [ADDR_WIDTH-1:0]      o_sram_addr,
  output logic [DATA_WIDTH-1:0]      o_sram_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [$clog2(FRAME_W)-1:0] o_h,
  output logic [$clog2(FRAME_H)-1:0] o_v
`ifdef FRAME_WRITER_CHECKSUM_EN
  ,
  output logic [15:0]                o_checksum
`endif
);

  localparam int unsigned HW = $clog2(FRAME_W);
  localparam int unsigned VW = $clog2(FRAME_H);
  localparam logic [HW-1:0]         HLast    = HW'(FRAME_W - 1);
  localparam logic [VW-1:0]         VLast    = VW'(FRAME_H - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrBase = ADDR_WIDTH'(BASE_ADDR);

  FwState state_q;
  logic   last_pix;

  assign last_pix = (o_h == HLast) && (o_v == VLast);

  // Every output is a flop; each transition loads the output values of the state it enters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= StIdle;
      o_pixel_ready  <= 1'b0;
      o_sram_writing <= 1'b0;
      o_sram_we_n    <= 1'b1;
      o_sram_addr    <= AddrBase;
      o_sram_data    <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_h            <= '0;
      o_v            <= '0;
`ifdef FRAME_WRITER_CHECKSUM_EN
      o_checksum     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            state_q       <= StWaitPix;
            o_h           <= '0;
            o_v           <= '0;
            o_done        <= 1'b0;
            o_sram_addr   <= AddrBase;
            o_busy        <= 1'b1;
            o_pixel_ready <= 1'b1;
`ifdef FRAME_WRITER_CHECKSUM_EN
            o_checksum    <= '0;
`endif
          end
        end

        StWaitPix: begin
          // Abort wins over a simultaneous pixel so no strobe is ever issued.
          if (i_abort) begin
            state_q       <= StIdle;
            o_pixel_ready <= 1'b0;
            o_busy        <= 1'b0;
          end else if (i_pixel_valid && o_pixel_ready) begin
            state_q        <= StSetup;
            o_sram_data    <= DATA_WIDTH'(rgb888_to_565(i_pixel));
            o_pixel_ready  <= 1'b0;
            o_sram_writing <= 1'b1;
          end
        end

        StSetup: begin
          if (i_abort) begin
            state_q        <= StIdle;
            o_sram_writing <= 1'b0;
            o_busy         <= 1'b0;
          end else begin
            state_q     <= StStrobe;
            o_sram_we_n <= 1'b0;
          end
        end

        StStrobe: begin
          o_sram_we_n    <= 1'b1;
          o_sram_writing <= 1'b0;
          o_sram_addr    <= o_sram_addr + ADDR_WIDTH'(1);
          if (o_h == HLast) begin
            o_h <= '0;
            o_v <= o_v + VW'(1);
          end else begin
            o_h <= o_h + HW'(1);
          end
`ifdef FRAME_WRITER_CHECKSUM_EN
          o_checksum <= o_checksum + 16'(o_sram_data);
`endif
          if (i_abort) begin
            state_q <= StIdle;
            o_busy  <= 1'b0;
          end else if (last_pix) begin
            state_q <= StDone;
            o_busy  <= 1'b0;
          end else begin
            state_q       <= StWaitPix;
            o_pixel_ready <= 1'b1;
          end
        end

        StDone: begin
          o_done  <= 1'b1;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_frame_writer.sv
// Directed/random bench for sram_frame_writer on a 4x2 frame at base 0x100.
module tb_sram_frame_writer;

  localparam int unsigned AW   = 20;
  localparam int unsigned DW   = 16;
  localparam int unsigned FW   = 4;
  localparam int unsigned FH   = 2;
  localparam int unsigned BASE = 32'h100;
  localparam int unsigned HW   = $clog2(FW);
  localparam int unsigned VW   = $clog2(FH);
  localparam int unsigned NPIX = FW * FH;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          start  = 1'b0;
  logic          abort  = 1'b0;
  logic          pvalid = 1'b0;
  logic [23:0]   pixel  = '0;
  logic          pready, writing, we_n, busy, done;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [15:0]   csum;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [23:0]   pix [NPIX];
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  int            wh[$];
  int            wv[$];
  logic          prev_setup = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  logic [DW-1:0] prev_data  = '0;

  sram_frame_writer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FRAME_W   (FW),
    .FRAME_H   (FH),
    .BASE_ADDR (BASE)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_abort       (abort),
    .i_pixel       (pixel),
    .i_pixel_valid (pvalid),
    .o_pixel_ready (pready),
    .o_sram_writing(writing),
    .o_sram_we_n   (we_n),
    .o_sram_addr   (addr),
    .o_sram_data   (data),
    .o_busy        (busy),
    .o_done        (done),
    .o_h           (h),
    .o_v           (v)
`ifdef FRAME_WRITER_CHECKSUM_EN
    ,
    .o_checksum    (csum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference packing written as channel arithmetic.
  function automatic logic [15:0] pack(input logic [23:0] p);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    return 16'(((r / 8) * 2048) + ((g / 4) * 32) + (b / 8));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Captures every strobe; a strobe must directly follow a SETUP cycle with identical bus values.
  always @(negedge clk) begin
    if (rst_n && !we_n) begin
      check("strobe_after_setup", 32'(prev_setup), 32'd1);
      check("addr_held", 32'(addr), 32'(prev_addr));
      check("data_held", 32'(data), 32'(prev_data));
      wa.push_back(addr);
      wd.push_back(data);
      wh.push_back(int'(h));
      wv.push_back(int'(v));
    end
    prev_setup = rst_n && writing && we_n;
    prev_addr  = addr;
    prev_data  = data;
  end

  task automatic reset_vals(input string tag);
    check({tag, "_ready"},   32'(pready),  32'd0);
    check({tag, "_writing"}, 32'(writing), 32'd0);
    check({tag, "_we_n"},    32'(we_n),    32'd1);
    check({tag, "_addr"},    32'(addr),    BASE);
    check({tag, "_data"},    32'(data),    32'd0);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_done"},    32'(done),    32'd0);
    check({tag, "_h"},       32'(h),       32'd0);
    check({tag, "_v"},       32'(v),       32'd0);
`ifdef FRAME_WRITER_CHECKSUM_EN
    check({tag, "_csum"},    32'(csum),    32'd0);
`endif
  endtask

  task automatic run_frame(input int gap_idx, input int gap_len, input int restart_idx,
                           input int abort_idx, input bit white, output int lat);
    int  idx, gap_left, st;
    bit  finished, gapping, restarted, acc;
    idx = 0; gap_left = gap_len; finished = 0; gapping = 0; restarted = 0;
    for (int i = 0; i < NPIX; i++) pix[i] = white ? 24'hFFFFFF : 24'($urandom);
    if (!white) pix[2] = 24'hFF8040;
    wa.delete(); wd.delete(); wh.delete(); wv.delete();
    lat = -1;
    start = 1'b1;
    st = cyc;
    tick();
    start = 1'b0;
    check("done_cleared_on_start", 32'(done), 32'd0);
    check("ready_after_start", 32'(pready), 32'd1);
    for (int k = 0; k < 400 && !finished; k++) begin
      abort = (abort_idx >= 0) && !we_n && (wa.size() == abort_idx);
      if (restart_idx >= 0 && !restarted && idx == restart_idx && pready) begin
        start = 1'b1;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      if (gap_left > 0 && (gapping || (idx == gap_idx && pready))) begin
        gapping = 1;
        gap_left--;
        pvalid = 1'b0;
        check("gap_ready", 32'(pready), 32'd1);
        check("gap_no_we", 32'(we_n), 32'd1);
      end else begin
        pvalid = (idx < NPIX);
      end
      pixel = pix[(idx < NPIX) ? idx : NPIX - 1];
      acc = pready && pvalid && !abort;
      tick();
      if (acc) idx++;
      if (done && lat < 0) begin
        lat = cyc - st;
        finished = 1;
      end
      if (abort_idx >= 0 && wa.size() > abort_idx && !busy) finished = 1;
    end
    start  = 1'b0;
    abort  = 1'b0;
    pvalid = 1'b0;
    check("run_finished", 32'(finished), 32'd1);
  endtask

  task automatic score(input int n, input string tag);
    check({tag, "_count"}, 32'(wa.size()), 32'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      int hh = i % FW;
      int vv = i / FW;
      check({tag, "_addr"}, 32'(wa[i]), BASE + 32'(vv * FW + hh));
      check({tag, "_data"}, 32'(wd[i]), 32'(pack(pix[i])));
      check({tag, "_h"},    32'(wh[i]), 32'(hh));
      check({tag, "_v"},    32'(wv[i]), 32'(vv));
    end
  endtask

  task automatic wait_setup(output bit seen);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (writing && we_n) seen = 1;
      else tick();
    end
    check("setup_reached", 32'(seen), 32'd1);
  endtask

  initial begin
    int lat;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    reset_vals("por");
    rst_n = 1'b1;
    tick();
    reset_vals("idle");

    // Full frame, valid held high
    run_frame(-1, 0, -1, -1, 1'b0, lat);
    score(NPIX, "full");
    check("full_latency", 32'(lat), 32'd26);
    check("pix_ff8040", 32'(wd.size() > 2 ? wd[2] : 16'h0), 32'h0000FC08);
    repeat (3) tick();
    check("done_sticky", 32'(done), 32'd1);
    check("idle_not_busy", 32'(busy), 32'd0);

    // Gap of 5 cycles between pixels 3 and 4
    run_frame(4, 5, -1, -1, 1'b0, lat);
    score(NPIX, "gap");
    check("gap_latency", 32'(lat), 32'd31);

    // Second start at pixel 2 is ignored
    run_frame(-1, 0, 2, -1, 1'b0, lat);
    score(NPIX, "restart");
    check("restart_latency", 32'(lat), 32'd26);

    // Abort during STROBE of pixel 5
    run_frame(-1, 0, -1, 5, 1'b0, lat);
    score(6, "abort_strobe");
    check("abort_strobe_done", 32'(done), 32'd0);
    check("abort_strobe_busy", 32'(busy), 32'd0);
    check("abort_strobe_ready", 32'(pready), 32'd0);
    check("abort_strobe_writing", 32'(writing), 32'd0);

    // Abort during SETUP: no strobe
    wa.delete();
    start = 1'b1; tick(); start = 1'b0;
    pvalid = 1'b1; pixel = 24'($urandom);
    wait_setup(seen);
    pvalid = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    tick();
    check("abort_setup_writes", 32'(wa.size()), 32'd0);
    check("abort_setup_busy", 32'(busy), 32'd0);
    check("abort_setup_writing", 32'(writing), 32'd0);
    check("abort_setup_done", 32'(done), 32'd0);

    // Reset asserted mid-SETUP releases the bus asynchronously
    start = 1'b1; tick(); start = 1'b0;
    pvalid = 1'b1; pixel = 24'($urandom);
    wait_setup(seen);
    check("pre_rst_writing", 32'(writing), 32'd1);
    pvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_vals("rst_setup");
    tick();
    rst_n = 1'b1;
    tick();
    reset_vals("post_rst");

`ifdef FRAME_WRITER_CHECKSUM_EN
    begin
      logic [15:0] sum;
      run_frame(-1, 0, -1, -1, 1'b1, lat);
      sum = '0;
      for (int i = 0; i < NPIX; i++) sum = sum + pack(pix[i]);
      check("csum_model", 32'(csum), 32'(sum));
      check("csum_white", 32'(csum), 32'h0000FFF8);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_frame_writer.md
# sram_frame_writer

Writes a full background frame into the external SRAM before gaming starts. It is the write side of the frame buffer whose read side is the frame decoder. It accepts a stream of RGB888 pixels over a valid/ready handshake, packs each pixel to RGB565, and issues one timed SRAM write per pixel in raster order. While it runs, it owns the SRAM bus through `o_sram_writing`, which top uses to mux address and data and to tri-state DQ.

## Interface
Parameters:
- `ADDR_WIDTH`, 20: SRAM address width (`sram_pkg::SRAM_ADDR_COUNT`).
- `DATA_WIDTH`, 16: SRAM data width (`sram_pkg::SRAM_DATA_WIDTH`).
- `FRAME_W`, 640: pixels per line.
- `FRAME_H`, 480: lines per frame.
- `BASE_ADDR`, 0: SRAM word address of pixel (0,0).

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset. Asynchronous, active-low; clock is `i_clk`.
- `i_start` in 1: single-cycle pulse that begins a frame load.
- `i_abort` in 1: terminates the load early.
- `i_pixel` in 24: RGB888 pixel as {R, G, B}.
- `i_pixel_valid` in 1: `i_pixel` is valid.
- `o_pixel_ready` out 1: the block can accept a pixel.
- `o_sram_writing` out 1: the block owns the SRAM bus.
- `o_sram_we_n` out 1: SRAM write strobe, active-low.
- `o_sram_addr` out ADDR_WIDTH: write address.
- `o_sram_data` out DATA_WIDTH: write data.
- `o_busy` out 1: a load is in progress.
- `o_done` out 1: sticky; the last frame completed.
- `o_h` out `clog2(FRAME_W)`: current pixel column.
- `o_v` out `clog2(FRAME_H)`: current pixel line.

## Operation
State machine with states IDLE, WAIT_PIX, SETUP, STROBE and DONE.

- **IDLE**
  - `i_start` → WAIT_PIX.
  - On the start: h and v are cleared, `o_done` is cleared and the address is set to `BASE_ADDR`.
- **WAIT_PIX**
  - `o_pixel_ready` = 1.
  - When `i_pixel_valid` & `o_pixel_ready`: register the data word {R[7:3], G[7:2], B[7:3]} → SETUP.
- **SETUP**
  - `o_sram_writing` = 1, `o_sram_we_n` = 1.
  - Address and data are stable on the bus.
  - → STROBE.
- **STROBE**
  - `o_sram_writing` = 1, `o_sram_we_n` = 0.
  - At the end of the cycle the pixel position advances:
    - Address increments by 1.
    - h increments; when h = FRAME_W−1, h wraps to 0 and v increments.
  - If the pixel just written was (FRAME_W−1, FRAME_H−1) → DONE; otherwise → WAIT_PIX.
- **DONE**
  - `o_done` = 1; → IDLE on the next cycle.
  - `o_done` stays high until the next `i_start` or reset.
- `o_busy` = 1 in WAIT_PIX, SETUP and STROBE.
- `i_start` has no effect in any state other than IDLE.
- `i_abort`:
  - In WAIT_PIX or SETUP: → IDLE on the next cycle; no write strobe is issued and `o_done` stays 0.
  - In STROBE: the strobe completes, then → IDLE.
- Pixels offered while `o_pixel_ready` = 0 are not consumed.
- Address arithmetic is `BASE_ADDR + v*FRAME_W + h` and must equal the incrementing counter. The counter is ADDR_WIDTH wide and must not overflow for the configured frame.

## Timing
- Reset values of all outputs:
  - `o_pixel_ready` = 0, `o_sram_writing` = 0, `o_sram_we_n` = 1.
  - `o_sram_addr` = `BASE_ADDR`, `o_sram_data` = 0.
  - `o_busy` = 0, `o_done` = 0, `o_h` = 0, `o_v` = 0.
  - State = IDLE.
- All outputs come directly from registers.
- Reset asserted mid-write releases the bus immediately and asynchronously: `o_sram_writing` = 0 and `o_sram_we_n` = 1.
- Latency: WAIT_PIX is entered 1 cycle after `i_start`.
- Each pixel takes at least 3 cycles: the accept cycle, SETUP, then STROBE.
- With `i_pixel_valid` held high, a full frame takes 3·FRAME_W·FRAME_H + 2 cycles from `i_start` to `o_done` rising.
- `o_sram_we_n` is low for exactly 1 cycle per pixel. Address and data are held constant from SETUP through STROBE.

## Configuration
- Macro: `FRAME_WRITER_CHECKSUM_EN`.
- **Defined:**
  - Adds output `o_checksum` (16 bits), reset to 0 and cleared on `i_start`.
  - In each STROBE cycle, `o_sram_data` is added to it modulo 2^16.
  - The value is final when `o_done` rises.
- **Undefined:** the port and the adder are absent.

## Structure
- `sram_pkg` holds:
  - The FRAME_W, FRAME_H and base-address constants.
  - An `rgb888_to_565` function.
- `game_pkg` holds the state enum `FwState` (IDLE, WAIT_PIX, SETUP, STROBE, DONE).
- No sub-module is used: one FSM and the counters live in a single module.

## Test plan
Run these scenarios with the bench configured as FRAME_W = 4, FRAME_H = 2, BASE_ADDR = 0x100:
- **Full frame:** `i_start`, then 8 pixels with valid held high. Required:
  - 8 WE pulses at addresses 0x100–0x107.
  - Pixel 0xFF8040 is written as 0xFC08.
  - `o_done` rises at cycle 26.
- **Gapped valid:** valid deasserted for 5 cycles between pixels 3 and 4. Required: `o_pixel_ready` stays high and no WE pulse occurs during the gap; addresses remain contiguous.
- **Start while busy:** `i_start` pulsed again at pixel 2. Required: it is ignored; address and h/v continue unaffected.
- **Abort in STROBE:** `i_abort` asserted on the STROBE cycle of pixel 5. Required: pixel 5 is written at 0x105, the block returns to IDLE, `o_done` = 0 and `o_busy` = 0.
- **Reset during SETUP:** reset asserted in SETUP. Required: `o_sram_writing` = 0 and `o_sram_we_n` = 1 within the same cycle, with all outputs at their reset values.
- **Checksum:** with `FRAME_WRITER_CHECKSUM_EN` defined, 8 pixels of 0xFFFFFF are written. Required: `o_checksum` = 0xFFF8.
